// File: rtl/apu_envelope_bank_if.sv
// Envelope bank bus: shared quarter-frame enable, per-channel controls and outputs.
interface apu_envelope_bank_if #(
   parameter int unsigned NCH   = 4,
   parameter int unsigned DEPTH = 4
);
   logic                   qframe;
   logic [NCH-1:0]         start;
   logic [NCH-1:0]         loop;
   logic [NCH-1:0]         const_vol;
   logic [NCH*DEPTH-1:0]   period;
   logic [NCH*DEPTH-1:0]   vol;
   logic [NCH-1:0]         tick;

   modport master (
      output qframe, start, loop, const_vol, period,
      input  vol, tick
   );

   modport slave (
      input  qframe, start, loop, const_vol, period,
      output vol, tick
   );
endinterface

// File: rtl/apu_envelope_bank.sv
// Bank of NCH independent APU-style envelope generators (divider + decay counter).
module apu_envelope_bank #(
   parameter int unsigned NCH   = 4,
   parameter int unsigned DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   apu_envelope_bank_if.slave bus
);

   localparam int unsigned SYNC_W = 2;
   localparam logic [DEPTH-1:0] DEC_MAX = '1;
   localparam logic [DEPTH-1:0] ONE     = DEPTH'(1);

   logic [SYNC_W-1:0]    rst_sync_q;
   logic                 run;
   logic [NCH-1:0]       flag_q, flag_d;
   logic [NCH-1:0]       tick_q, tick_d;
   logic [DEPTH-1:0]     div_q [NCH];
   logic [DEPTH-1:0]     div_d [NCH];
   logic [DEPTH-1:0]     dec_q [NCH];
   logic [DEPTH-1:0]     dec_d [NCH];
   logic [NCH*DEPTH-1:0] vol_q, vol_d;

   // Release synchroniser: state only advances once reset release has crossed two flops.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rst_sync_q <= '0;
      end else begin
         rst_sync_q <= {rst_sync_q[SYNC_W-2:0], 1'b1};
      end
   end

   assign run = rst_sync_q[SYNC_W-1];

   // Channel state and registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         flag_q <= '0;
         tick_q <= '0;
         vol_q  <= '0;
         for (int unsigned i = 0; i < NCH; i++) begin
            div_q[i] <= '0;
            dec_q[i] <= '0;
         end
      end else begin
         flag_q <= flag_d;
         tick_q <= tick_d;
         vol_q  <= vol_d;
         for (int unsigned i = 0; i < NCH; i++) begin
            div_q[i] <= div_d[i];
            dec_q[i] <= dec_d[i];
         end
      end
   end

   // Per-channel next state: qframe uses the pre-edge start flag, a new start re-arms it.
   always_comb begin
      flag_d = flag_q;
      tick_d = '0;
      vol_d  = '0;
      for (int unsigned i = 0; i < NCH; i++) begin
         div_d[i] = div_q[i];
         dec_d[i] = dec_q[i];
      end

      if (run) begin
         for (int unsigned i = 0; i < NCH; i++) begin
            vol_d[i*DEPTH +: DEPTH] = bus.const_vol[i] ? bus.period[i*DEPTH +: DEPTH] : dec_q[i];

            if (bus.qframe) begin
               if (flag_q[i]) begin
                  flag_d[i] = 1'b0;
                  dec_d[i]  = DEC_MAX;
                  div_d[i]  = bus.period[i*DEPTH +: DEPTH];
               end else if (div_q[i] != '0) begin
                  div_d[i] = div_q[i] - ONE;
               end else begin
                  div_d[i]  = bus.period[i*DEPTH +: DEPTH];
                  tick_d[i] = 1'b1;
                  if (dec_q[i] != '0) begin
                     dec_d[i] = dec_q[i] - ONE;
                  end else if (bus.loop[i]) begin
                     dec_d[i] = DEC_MAX;
                  end
               end
            end

            if (bus.start[i]) begin
               flag_d[i] = 1'b1;
            end
         end
      end
   end

   assign bus.vol  = vol_q;
   assign bus.tick = tick_q;

endmodule

// File: tb/tb_apu_envelope_bank.sv
// Directed bench for apu_envelope_bank with a per-cycle reference model of all four channels.
module tb_apu_envelope_bank;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   int   m_flag [4];
   int   m_div  [4];
   int   m_dec  [4];
   int   tcnt;
   string phase;

   apu_envelope_bank_if #(.NCH(4), .DEPTH(4)) bus ();

   apu_envelope_bank #(.NCH(4), .DEPTH(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_flag[i] = 0;
         m_div[i]  = 0;
         m_dec[i]  = 0;
      end
   endtask

   // One clock cycle: drive inputs at negedge, advance the model, compare at the next negedge.
   task automatic cyc(input logic qf, input logic [3:0] st);
      logic [15:0] ev;
      logic [3:0]  et;
      int          v;
      ev = '0;
      et = '0;
      bus.qframe = qf;
      bus.start  = st;
      for (int i = 0; i < 4; i++) begin
         v = int'(bus.period[i*4 +: 4]);
         ev[i*4 +: 4] = bus.const_vol[i] ? 4'(v) : 4'(m_dec[i]);
         if (qf) begin
            if (m_flag[i] != 0) begin
               m_flag[i] = 0;
               m_dec[i]  = 15;
               m_div[i]  = v;
            end else if (m_div[i] > 0) begin
               m_div[i] = m_div[i] - 1;
            end else begin
               m_div[i] = v;
               et[i]    = 1'b1;
               if (m_dec[i] > 0) m_dec[i] = m_dec[i] - 1;
               else if (bus.loop[i]) m_dec[i] = 15;
            end
         end
         if (st[i]) m_flag[i] = 1;
      end
      @(negedge clk);
      bus.qframe = 1'b0;
      bus.start  = '0;
      chk({phase, ".vol"}, 32'(bus.vol), 32'(ev));
      chk({phase, ".tick"}, 32'(bus.tick), 32'(et));
   endtask

   initial begin
      checks = 0;
      errors = 0;
      tcnt   = 0;
      model_reset();
      rst           = 1'b0;
      bus.qframe    = 1'b0;
      bus.start     = '0;
      bus.loop      = '0;
      bus.const_vol = 4'hF;
      bus.period    = 16'h9999;
      repeat (3) @(negedge clk);
      chk("rst_vol", 32'(bus.vol), 32'h0);
      chk("rst_tick", 32'(bus.tick), 32'h0);

      bus.const_vol = '0;
      bus.period    = 16'h0002;
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // ch0 V=2, one-shot decay
      phase = "a";
      cyc(1'b0, 4'b0001);
      cyc(1'b1, 4'b0000);
      cyc(1'b0, 4'b0000);
      chk("a_dec15", 32'(bus.vol[3:0]), 32'd15);
      for (int k = 1; k <= 45; k++) begin
         cyc(1'b1, 4'b0000);
         chk("a_tick", 32'(bus.tick[0]), (k % 3 == 0) ? 32'd1 : 32'd0);
         if (bus.tick[0]) tcnt++;
         if (k == 4) chk("a_dec14", 32'(bus.vol[3:0]), 32'd14);
      end
      chk("a_ticks", 32'(tcnt), 32'd15);
      cyc(1'b0, 4'b0000);
      chk("a_dec0", 32'(bus.vol[3:0]), 32'd0);
      for (int k = 0; k < 3; k++) cyc(1'b1, 4'b0000);
      cyc(1'b0, 4'b0000);
      chk("a_hold0", 32'(bus.vol[3:0]), 32'd0);

      // loop on ch0: next expiry reloads 15
      phase = "b";
      bus.loop = 4'b0001;
      for (int k = 0; k < 3; k++) cyc(1'b1, 4'b0000);
      cyc(1'b0, 4'b0000);
      chk("b_reload", 32'(bus.vol[3:0]), 32'd15);
      for (int k = 0; k < 48; k++) cyc(1'b1, 4'b0000);
      cyc(1'b0, 4'b0000);
      chk("b_reload2", 32'(bus.vol[3:0]), 32'd15);

      // ch1 V=0: decrements on every qframe after the start qframe
      phase = "c";
      cyc(1'b0, 4'b0010);
      cyc(1'b1, 4'b0000);
      for (int k = 0; k < 5; k++) begin
         cyc(1'b1, 4'b0000);
         chk("c_tick", 32'(bus.tick[1]), 32'd1);
      end
      cyc(1'b0, 4'b0000);
      chk("c_dec10", 32'(bus.vol[7:4]), 32'd10);

      // ch2: start and qframe together while flag clear
      phase = "d";
      bus.period = 16'h0102;
      cyc(1'b1, 4'b0100);
      chk("d_tick", 32'(bus.tick[2]), 32'd1);
      cyc(1'b1, 4'b0000);
      chk("d_notick", 32'(bus.tick[2]), 32'd0);
      cyc(1'b0, 4'b0000);
      chk("d_dec15", 32'(bus.vol[11:8]), 32'd15);

      // ch3: constant volume select
      phase = "e";
      bus.period = 16'h9102;
      cyc(1'b0, 4'b1000);
      cyc(1'b1, 4'b0000);
      bus.const_vol = 4'b1000;
      cyc(1'b0, 4'b0000);
      chk("e_const9", 32'(bus.vol[15:12]), 32'd9);
      bus.const_vol = 4'b0000;
      cyc(1'b0, 4'b0000);
      chk("e_decay15", 32'(bus.vol[15:12]), 32'd15);

      // all channels, different periods and staggered starts
      phase = "f";
      bus.period = 16'h2031;
      bus.loop   = 4'b0101;
      for (int c = 0; c < 60; c++) begin
         logic [3:0] st;
         st = (c == 0)  ? 4'b0001 :
              (c == 5)  ? 4'b0010 :
              (c == 11) ? 4'b0100 :
              (c == 17) ? 4'b1000 :
              (c == 20) ? 4'b0001 : 4'b0000;
         cyc((c % 2 == 0) || (c % 5 == 0), st);
      end

      // asynchronous reset mid-run, pending start discarded
      bus.start = 4'b0010;
      #2 rst = 1'b0;
      bus.start = '0;
      #1;
      chk("g_rst_vol", 32'(bus.vol), 32'h0);
      chk("g_rst_tick", 32'(bus.tick), 32'h0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      phase = "g";
      for (int k = 0; k < 4; k++) cyc(1'b0, 4'b0000);
      chk("g_silent", 32'(bus.vol), 32'h0);
      cyc(1'b0, 4'b0001);
      cyc(1'b1, 4'b0000);
      cyc(1'b0, 4'b0000);
      chk("g_restart", 32'(bus.vol[3:0]), 32'd15);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
